card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
- Consumes the free-running 9-bit random word from lfsr9 and deals playing cards from a single 52-card deck, without replacement.
- Tracks dealt cards in a 52-bit bitmap. A collision is resolved by a linear probe with wrap-around.
- Presents rank, suit and Blackjack point value to the game FSM through a request/valid handshake.

Parameters:
- RND_W, 9, width of the rnd input; must be >= 6; only rnd[5:0] is used.
- ACE_HIGH, 1, 1: ace point value = 11; 0: ace point value = 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rnd  input  RND_W  random word from lfsr9, sampled only when a draw is accepted.
- shuffle  input  1  one-cycle pulse; returns all 52 cards to the deck.
- draw_req  input  1  request one card; accepted only when busy=0.
- busy  output  1  draw in progress.
- card_valid  output  1  one-cycle pulse; card outputs are valid in this cycle.
- card_rank  output  4  1..13 (A, 2..10, J, Q, K).
- card_suit  output  2  0..3.
- card_points  output  4  Blackjack value: A = 11 or 1 per ACE_HIGH, 2..10 face value, J/Q/K = 10.
- cards_left  output  6  undealt cards, 0..52.
- empty_err  output  1  one-cycle pulse when draw_req is accepted with cards_left = 0.

Behaviour:
- Reset (async, rst=1):
  - State IDLE, bitmap all zero.
  - cards_left = 52.
  - busy, card_valid, empty_err = 0; card_rank, card_suit, card_points = 0.
- States: IDLE, PROBE.
- IDLE, draw_req=1, shuffle=0, cards_left>0:
  - Latch idx = rnd[5:0] if < 52, else rnd[5:0] - 12 (52..63 map to 40..51).
  - Go to PROBE; busy = 1 from the next cycle.
- IDLE, draw_req=1, cards_left=0:
  - empty_err pulses next cycle; state stays IDLE; no card.
- PROBE:
  - If dealt[idx]=1: idx = (idx==51) ? 0 : idx+1; stay in PROBE.
  - If dealt[idx]=0: set dealt[idx]; cards_left decrements.
  - In that free-slot case, register the outputs: suit = idx/13, rank = idx%13 + 1, points.
  - card_valid = 1 for one cycle, busy = 0, return to IDLE.
- Latency:
  - card_valid is high 2 cycles after the accepting edge when there is no collision.
  - Each collision adds 1 cycle; worst case is 53 cycles.
  - PROBE always terminates because cards_left > 0 is guaranteed on entry.
- Back-to-back draws: draw_req may be reasserted in the card_valid cycle; it is accepted because busy = 0.
- draw_req while busy: ignored, not queued.
- shuffle:
  - Has priority over everything.
  - Next cycle: bitmap cleared, cards_left = 52, state IDLE, busy = 0.
  - An in-flight draw is aborted with no card_valid.
  - A draw_req in the same cycle is dropped.
- card_rank, card_suit and card_points hold their last values until the next card_valid.
- cards_left is never decremented below 0 and never exceeds 52.

Optional Feature:
- Macro CARD_DEALER_PEEK_EN.
- Defined: adds output dealt_map[51:0], the live bitmap, for debug and LED display.
- Undefined: the port is absent; function is otherwise identical.

Decomposition:
- Package blackjack_pkg holds:
  - DECK_SIZE=52, RANKS=13, SUITS=4.
  - typedef card_t {rank[3:0], suit[1:0], points[3:0]}.
  - enum dealer_state_e {IDLE, PROBE}.
- Sub-module card_decode: combinational, idx[5:0] -> card_t, with ACE_HIGH passed through.

Test Plan:
- Reset, then rnd=0, draw_req -> card_valid 2 cycles later; rank 1, suit 0, points 11; cards_left 51.
- rnd=0 again -> collision at idx 0, probe to idx 1; card_valid 3 cycles after accept; rank 2, points 2.
- rnd=60 -> idx 48; suit 3, rank 10, points 10. Next, rnd=51 (idx 51, rank 13) twice -> second draw wraps to idx 2 (0 and 1 already dealt); rank 3, suit 0.
- 52 draws with random rnd -> all 52 (suit, rank) pairs distinct; cards_left 0. 53rd draw -> empty_err pulse, no card_valid.
- shuffle asserted during a long PROBE -> no card_valid; cards_left 52; busy 0 next cycle. shuffle with draw_req in the same cycle -> draw dropped.
- rst asserted mid-PROBE, asynchronously -> outputs return to reset values immediately. ACE_HIGH=0 build -> ace points = 1.

Source files
------------

// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - deck constants, card record, dealer states and index helpers
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int SUITS     = 4;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
        logic [3:0] points;
    } card_t;

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } dealer_state_e;

    // Fold the 64 possible 6-bit values onto the deck; 52..63 land on 40..51.
    function automatic logic [5:0] map_rnd(input logic [5:0] r);
        return (r < 6'(DECK_SIZE)) ? r : r - 6'd12;
    endfunction

    // Linear probe step with wrap from the last card back to the first.
    function automatic logic [5:0] next_idx(input logic [5:0] i);
        return (i == 6'(DECK_SIZE - 1)) ? 6'd0 : i + 6'd1;
    endfunction

endpackage

// File: rtl/card_decode.sv
// rtl/card_decode.sv - combinational deck index to rank, suit and blackjack points
module card_decode
    import blackjack_pkg::*;
#(
    parameter int ACE_HIGH = 1
) (
    input  logic [5:0] idx,
    output card_t      card
);

    logic [1:0] suit;
    logic [3:0] rank;

    // Split the index into suit (idx / 13) and rank (idx % 13 + 1), then score it.
    always_comb begin
        suit = 2'd0;
        rank = 4'(idx) + 4'd1;
        if (idx >= 6'(3 * RANKS)) begin
            suit = 2'd3;
            rank = 4'(idx - 6'(3 * RANKS)) + 4'd1;
        end else if (idx >= 6'(2 * RANKS)) begin
            suit = 2'd2;
            rank = 4'(idx - 6'(2 * RANKS)) + 4'd1;
        end else if (idx >= 6'(RANKS)) begin
            suit = 2'd1;
            rank = 4'(idx - 6'(RANKS)) + 4'd1;
        end
        card.rank = rank;
        card.suit = suit;
        if (rank == 4'd1) begin
            card.points = (ACE_HIGH != 0) ? 4'd11 : 4'd1;
        end else if (rank >= 4'd10) begin
            card.points = 4'd10;
        end else begin
            card.points = rank;
        end
    end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - single-deck dealer without replacement; CARD_DEALER_PEEK_EN exposes dealt_map
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int RND_W    = 9,
    parameter int ACE_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RND_W-1:0] rnd,
    input  logic             shuffle,
    input  logic             draw_req,
    output logic             busy,
    output logic             card_valid,
    output logic [3:0]       card_rank,
    output logic [1:0]       card_suit,
    output logic [3:0]       card_points,
    output logic [5:0]       cards_left,
`ifdef CARD_DEALER_PEEK_EN
    output logic [51:0]      dealt_map,
`endif
    output logic             empty_err
);

    dealer_state_e state;
    dealer_state_e state_nxt;
    logic [5:0]    idx;
    logic [51:0]   dealt;
    card_t         dec_card;
    logic          accept;
    logic          empty_hit;
    logic          slot_taken;

    if (RND_W > 6) begin : g_rnd_hi
        logic unused_rnd_hi;
        assign unused_rnd_hi = ^rnd[RND_W-1:6];
    end

    card_decode #(
        .ACE_HIGH (ACE_HIGH)
    ) u_card_decode (
        .idx  (idx),
        .card (dec_card)
    );

`ifdef CARD_DEALER_PEEK_EN
    assign dealt_map = dealt;
`endif

    // State register; shuffle handling lives in the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: shuffle forces IDLE, accepted draws probe until a free slot turns up.
    always_comb begin
        state_nxt = state;
        if (shuffle) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = PROBE;
                PROBE:   if (!slot_taken) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Decode outputs and handshake qualifiers from the current state.
    always_comb begin
        busy       = (state == PROBE);
        slot_taken = dealt[idx];
        accept     = (state == IDLE) && draw_req && !shuffle && (cards_left != 6'd0);
        empty_hit  = (state == IDLE) && draw_req && !shuffle && (cards_left == 6'd0);
    end

    // Datapath: probe index, dealt bitmap, deck count and registered card outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= 6'd0;
            dealt       <= '0;
            cards_left  <= 6'(DECK_SIZE);
            card_valid  <= 1'b0;
            empty_err   <= 1'b0;
            card_rank   <= 4'd0;
            card_suit   <= 2'd0;
            card_points <= 4'd0;
        end else begin
            card_valid <= 1'b0;
            empty_err  <= 1'b0;
            if (shuffle) begin
                dealt      <= '0;
                cards_left <= 6'(DECK_SIZE);
            end else if (accept) begin
                idx <= map_rnd(rnd[5:0]);
            end else if (empty_hit) begin
                empty_err <= 1'b1;
            end else if (state == PROBE) begin
                if (slot_taken) begin
                    idx <= next_idx(idx);
                end else begin
                    dealt[idx]  <= 1'b1;
                    cards_left  <= cards_left - 6'd1;
                    card_valid  <= 1'b1;
                    card_rank   <= dec_card.rank;
                    card_suit   <= dec_card.suit;
                    card_points <= dec_card.points;
                end
            end
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - randomized self-checking bench for card_dealer against a deck model
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] rnd;
    logic       shuffle;
    logic       draw_req;

    logic       busy, card_valid, empty_err;
    logic [3:0] card_rank, card_points;
    logic [1:0] card_suit;
    logic [5:0] cards_left;

    logic       lo_busy, lo_card_valid, lo_empty_err;
    logic [3:0] lo_card_rank, lo_card_points;
    logic [1:0] lo_card_suit;
    logic [5:0] lo_cards_left;

`ifdef CARD_DEALER_PEEK_EN
    logic [51:0] dealt_map, lo_dealt_map;
`endif

    card_dealer #(.RND_W(9), .ACE_HIGH(1)) dut (
        .clk(clk), .rst(rst), .rnd(rnd), .shuffle(shuffle), .draw_req(draw_req),
        .busy(busy), .card_valid(card_valid), .card_rank(card_rank), .card_suit(card_suit),
        .card_points(card_points), .cards_left(cards_left),
`ifdef CARD_DEALER_PEEK_EN
        .dealt_map(dealt_map),
`endif
        .empty_err(empty_err)
    );

    card_dealer #(.RND_W(9), .ACE_HIGH(0)) dut_lo (
        .clk(clk), .rst(rst), .rnd(rnd), .shuffle(shuffle), .draw_req(draw_req),
        .busy(lo_busy), .card_valid(lo_card_valid), .card_rank(lo_card_rank), .card_suit(lo_card_suit),
        .card_points(lo_card_points), .cards_left(lo_cards_left),
`ifdef CARD_DEALER_PEEK_EN
        .dealt_map(lo_dealt_map),
`endif
        .empty_err(lo_empty_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit   mdealt[52];
    int   mleft;
    bit   e_ok;
    int   e_idx;
    int   e_coll;

    int   obs_lat;
    logic obs_valid, obs_empty, obs_busy1;

    function automatic int exp_points(input int rank, input int ace_high);
        if (rank == 1) return (ace_high != 0) ? 11 : 1;
        if (rank > 10) return 10;
        return rank;
    endfunction

    task automatic model_clear();
        foreach (mdealt[i]) mdealt[i] = 1'b0;
        mleft = 52;
    endtask

    task automatic model_draw(input logic [8:0] r);
        int start;
        start  = int'(r) % 64;
        e_coll = 0;
        if (mleft == 0) begin
            e_ok = 1'b0;
            return;
        end
        e_ok  = 1'b1;
        e_idx = (start < 52) ? start : start - 12;
        while (mdealt[e_idx]) begin
            e_idx  = (e_idx + 1) % 52;
            e_coll = e_coll + 1;
        end
        mdealt[e_idx] = 1'b1;
        mleft = mleft - 1;
    endtask

    // Issues one draw at posedge+1 and waits for card_valid or empty_err.
    task automatic issue_draw(input logic [8:0] r);
        rnd       = r;
        draw_req  = 1'b1;
        obs_lat   = 0;
        obs_valid = 1'b0;
        obs_empty = 1'b0;
        obs_busy1 = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            draw_req = 1'b0;
            rnd      = 9'($urandom);
            if (i == 1) obs_busy1 = busy;
            if (card_valid || empty_err) begin
                obs_lat   = i;
                obs_valid = card_valid;
                obs_empty = empty_err;
                break;
            end
        end
    endtask

    task automatic do_shuffle();
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (card_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", card_valid); end
        n_checks++; if (empty_err !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %b want 0", empty_err); end
        n_checks++; if (card_rank !== 4'd0 || card_suit !== 2'd0 || card_points !== 4'd0) begin
            n_fail++; $display("FAIL reset_card: got r%0d s%0d p%0d want 0 0 0", card_rank, card_suit, card_points);
        end
        n_checks++; if (cards_left !== 6'd52) begin n_fail++; $display("FAIL reset_left: got %0d want 52", cards_left); end
    endtask

    task automatic test_basic();
        logic [8:0] tbl[5];
        tbl = '{9'd0, 9'd0, 9'd60, 9'd51, 9'd51};
        for (int k = 0; k < 5; k++) begin
            model_draw(tbl[k]);
            issue_draw(tbl[k]);
            n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b want 1", k, obs_valid); end
            n_checks++; if (obs_lat != 2 + e_coll) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d want %0d", k, obs_lat, 2 + e_coll); end
            n_checks++; if (obs_busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0d]: got %b want 1", k, obs_busy1); end
            n_checks++; if (card_rank !== 4'(e_idx % 13 + 1)) begin n_fail++; $display("FAIL basic_rank[%0d]: got %0d want %0d", k, card_rank, e_idx % 13 + 1); end
            n_checks++; if (card_suit !== 2'(e_idx / 13)) begin n_fail++; $display("FAIL basic_suit[%0d]: got %0d want %0d", k, card_suit, e_idx / 13); end
            n_checks++; if (card_points !== 4'(exp_points(e_idx % 13 + 1, 1))) begin
                n_fail++; $display("FAIL basic_points[%0d]: got %0d want %0d", k, card_points, exp_points(e_idx % 13 + 1, 1));
            end
            n_checks++; if (lo_card_points !== 4'(exp_points(e_idx % 13 + 1, 0))) begin
                n_fail++; $display("FAIL basic_points_acelow[%0d]: got %0d want %0d", k, lo_card_points, exp_points(e_idx % 13 + 1, 0));
            end
            n_checks++; if (cards_left !== 6'(mleft)) begin n_fail++; $display("FAIL basic_left[%0d]: got %0d want %0d", k, cards_left, mleft); end
        end
    endtask

    task automatic test_back_to_back_full_deck();
        bit         seen[52];
        int         pos;
        int         nv;
        logic [8:0] r;
        do_shuffle();
        foreach (seen[i]) seen[i] = 1'b0;
        for (int k = 0; k < 52; k++) begin
            r = 9'($urandom);
            model_draw(r);
            issue_draw(r);
            n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL deck_valid[%0d]: got %b want 1", k, obs_valid); end
            n_checks++; if (obs_lat != 2 + e_coll) begin n_fail++; $display("FAIL deck_latency[%0d]: got %0d want %0d", k, obs_lat, 2 + e_coll); end
            n_checks++; if (card_rank !== 4'(e_idx % 13 + 1) || card_suit !== 2'(e_idx / 13)) begin
                n_fail++; $display("FAIL deck_card[%0d]: got r%0d s%0d want r%0d s%0d", k, card_rank, card_suit, e_idx % 13 + 1, e_idx / 13);
            end
            n_checks++; if (card_points !== 4'(exp_points(e_idx % 13 + 1, 1)) || lo_card_points !== 4'(exp_points(e_idx % 13 + 1, 0))) begin
                n_fail++; $display("FAIL deck_points[%0d]: got %0d/%0d want %0d/%0d", k, card_points, lo_card_points,
                                   exp_points(e_idx % 13 + 1, 1), exp_points(e_idx % 13 + 1, 0));
            end
            n_checks++; if (cards_left !== 6'(mleft)) begin n_fail++; $display("FAIL deck_left[%0d]: got %0d want %0d", k, cards_left, mleft); end
            pos = int'(card_suit) * 13 + int'(card_rank) - 1;
            n_checks++;
            if (pos < 0 || pos > 51) begin
                n_fail++; $display("FAIL deck_distinct[%0d]: got position %0d want 0..51", k, pos);
            end else if (seen[pos]) begin
                n_fail++; $display("FAIL deck_distinct[%0d]: got repeat of position %0d want unseen", k, pos);
            end else begin
                seen[pos] = 1'b1;
            end
        end
        model_draw(9'($urandom));
        issue_draw(9'($urandom));
        n_checks++; if (obs_empty !== 1'b1 || obs_lat != 1) begin
            n_fail++; $display("FAIL empty_err: got %b at cycle %0d want 1 at cycle 1", obs_empty, obs_lat);
        end
        n_checks++; if (obs_valid !== 1'b0 || e_ok) begin n_fail++; $display("FAIL empty_no_card: got valid %b want 0", obs_valid); end
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (card_valid || busy || empty_err) nv++;
        end
        n_checks++; if (nv != 0) begin n_fail++; $display("FAIL empty_quiet: got %0d active cycles want 0", nv); end
        n_checks++; if (cards_left !== 6'd0) begin n_fail++; $display("FAIL empty_left: got %0d want 0", cards_left); end
    endtask

    task automatic test_busy_ignore();
        int nv;
        int lat;
        do_shuffle();
        for (int k = 0; k < 4; k++) begin
            model_draw(9'(k));
            issue_draw(9'(k));
        end
        model_draw(9'd0);
        rnd = 9'd0; draw_req = 1'b1;
        @(posedge clk); #1;
        rnd = 9'd30;
        @(posedge clk); #1;
        draw_req = 1'b0;
        lat = 0;
        for (int i = 3; i <= 60; i++) begin
            @(posedge clk); #1;
            if (card_valid) begin lat = i; break; end
        end
        n_checks++; if (lat != 2 + e_coll) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat, 2 + e_coll); end
        n_checks++; if (card_rank !== 4'(e_idx % 13 + 1)) begin n_fail++; $display("FAIL ignore_rank: got %0d want %0d", card_rank, e_idx % 13 + 1); end
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (card_valid || busy) nv++;
        end
        n_checks++; if (nv != 0 || cards_left !== 6'(mleft)) begin
            n_fail++; $display("FAIL ignore_queued: got %0d extra cycles, left %0d want 0, %0d", nv, cards_left, mleft);
        end
    endtask

    task automatic test_shuffle();
        int nv;
        do_shuffle();
        for (int k = 0; k < 20; k++) begin
            model_draw(9'(k));
            issue_draw(9'(k));
        end
        n_checks++; if (cards_left !== 6'(mleft)) begin n_fail++; $display("FAIL shuffle_setup_left: got %0d want %0d", cards_left, mleft); end
        rnd = 9'd0; draw_req = 1'b1;
        @(posedge clk); #1;
        draw_req = 1'b0;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (card_valid) nv++;
        end
        n_checks++; if (busy !== 1'b1 || nv != 0) begin n_fail++; $display("FAIL shuffle_probe: got busy %b valid %0d want 1 0", busy, nv); end
        do_shuffle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL shuffle_busy: got %b want 0", busy); end
        n_checks++; if (cards_left !== 6'd52) begin n_fail++; $display("FAIL shuffle_left: got %0d want 52", cards_left); end
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (card_valid) nv++;
        end
        n_checks++; if (nv != 0) begin n_fail++; $display("FAIL shuffle_abort: got %0d card_valid want 0", nv); end
        rnd = 9'd5; draw_req = 1'b1; shuffle = 1'b1;
        @(posedge clk); #1;
        draw_req = 1'b0; shuffle = 1'b0;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            if (card_valid || busy) nv++;
            @(posedge clk); #1;
        end
        n_checks++; if (nv != 0 || cards_left !== 6'd52) begin
            n_fail++; $display("FAIL shuffle_drop: got %0d active cycles, left %0d want 0, 52", nv, cards_left);
        end
    endtask

    task automatic test_async_reset();
        do_shuffle();
        for (int k = 0; k < 3; k++) begin
            model_draw(9'(k));
            issue_draw(9'(k));
        end
        rnd = 9'd0; draw_req = 1'b1;
        @(posedge clk); #1;
        draw_req = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_probe: got busy %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || card_valid !== 1'b0 || empty_err !== 1'b0) begin
            n_fail++; $display("FAIL areset_flags: got b%b v%b e%b want 0 0 0", busy, card_valid, empty_err);
        end
        n_checks++; if (card_rank !== 4'd0 || card_suit !== 2'd0 || card_points !== 4'd0 || cards_left !== 6'd52) begin
            n_fail++; $display("FAIL areset_outputs: got r%0d s%0d p%0d l%0d want 0 0 0 52", card_rank, card_suit, card_points, cards_left);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        model_draw(9'd7);
        issue_draw(9'd7);
        n_checks++; if (obs_valid !== 1'b1 || obs_lat != 2 || card_rank !== 4'(e_idx % 13 + 1)) begin
            n_fail++; $display("FAIL areset_redraw: got v%b lat%0d r%0d want 1 2 %0d", obs_valid, obs_lat, card_rank, e_idx % 13 + 1);
        end
    endtask

    initial begin
        rst = 1'b1; shuffle = 1'b0; draw_req = 1'b0; rnd = 9'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back_full_deck();
        test_busy_ignore();
        test_shuffle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
